// File: rtl/lens_cmd_sequencer.sv
// lens_cmd_sequencer: lens command front-end producing start/clear pulses with settle hold-off (optional idle auto-clear via LENS_AUTO_CLEAR_EN)
module lens_cmd_sequencer #(
  parameter int PULSE_LEN = 2,
  parameter int SETTLE_CYCLES = 10860050,
  parameter int CNT_W = 24,
  parameter int AUTO_CLEAR_CYCLES = 16000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cmd_valid,
  input  logic [2:0] cmd_code,
  output logic       cmd_ready,
  output logic       l_start,
  output logic       r_start,
  output logic       l_clear,
  output logic       r_clear,
  output logic       busy,
  output logic       l_dark,
  output logic       r_dark,
  output logic       cmd_err
);
  typedef enum logic [1:0] {IDLE, PULSE, SETTLE} state_t;
  state_t state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [3:0] pls, pls_n;
  logic l_dark_n, r_dark_n, accept, auto_go, l_tgt, r_tgt, l_act, r_act;
  logic [2:0] code;
  assign accept = cmd_valid && cmd_ready;
`ifdef LENS_AUTO_CLEAR_EN
  logic [CNT_W-1:0] idle_cnt;
  assign auto_go = state == IDLE && cmd_ready && (l_dark || r_dark) &&
                   idle_cnt == CNT_W'(AUTO_CLEAR_CYCLES - 1);
  always_ff @(posedge clk)
    if (rst || state != IDLE || !cmd_ready || accept || auto_go || !(l_dark || r_dark)) idle_cnt <= '0;
    else idle_cnt <= idle_cnt + 1'b1;
`else
  assign auto_go = 1'b0;
`endif
  // an auto-clear is an internal clear-both; an external accept always takes priority
  assign code  = accept ? cmd_code : 3'b110;
  assign l_tgt = code == 3'b111 ? !l_dark : code inside {3'b001, 3'b011} ? 1'b1 :
                 code inside {3'b100, 3'b110} ? 1'b0 : l_dark;
  assign r_tgt = code == 3'b111 ? !r_dark : code inside {3'b010, 3'b011} ? 1'b1 :
                 code inside {3'b101, 3'b110} ? 1'b0 : r_dark;
  assign l_act = (accept || auto_go) && l_tgt != l_dark;
  assign r_act = (accept || auto_go) && r_tgt != r_dark;
  assign {l_start, r_start, l_clear, r_clear} = pls;
  always_comb begin
    state_n  = state;
    cnt_n    = cnt;
    pls_n    = pls;
    l_dark_n = l_dark;
    r_dark_n = r_dark;
    if (state == IDLE) begin
      if (l_act || r_act) begin
        state_n  = PULSE;
        cnt_n    = '0;
        pls_n    = {l_act && l_tgt, r_act && r_tgt, l_act && !l_tgt, r_act && !r_tgt};
        l_dark_n = l_tgt;
        r_dark_n = r_tgt;
      end
    end else if (cnt == CNT_W'(state == PULSE ? PULSE_LEN - 1 : SETTLE_CYCLES - 1)) begin
      state_n = state == PULSE ? SETTLE : IDLE;
      cnt_n   = '0;
      pls_n   = '0;
    end else cnt_n = cnt + 1'b1;
  end
  always_ff @(posedge clk)
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      pls       <= '0;
      l_dark    <= 1'b0;
      r_dark    <= 1'b0;
      cmd_err   <= 1'b0;
      cmd_ready <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      pls       <= pls_n;
      l_dark    <= l_dark_n;
      r_dark    <= r_dark_n;
      cmd_err   <= accept && cmd_code == 3'b000;
      cmd_ready <= state_n == IDLE;
      busy      <= state_n != IDLE;
    end
endmodule

// File: doc/lens_cmd_sequencer.md
Name: lens_cmd_sequencer

Overview:
- Command front-end directly upstream of the left/right lens drive stage; generates its l_start, r_start, l_clear and r_clear request pulses.
- Accepts 3-bit lens commands over a valid/ready handshake and tracks the commanded state of each lens.
- Emits fixed-width start/clear pulses, then holds off new commands for the drive settle interval.

Parameters:
- PULSE_LEN, 2, cycles each start/clear output is held high; legal range 1..255.
- SETTLE_CYCLES, 10860050, hold-off cycles after the pulse before the next command is accepted; must be >= 1.
- CNT_W, 24, width of the settle and auto-clear counters; must hold SETTLE_CYCLES and AUTO_CLEAR_CYCLES.
- AUTO_CLEAR_CYCLES, 16000000, idle-dark cycles before an automatic clear; used only with LENS_AUTO_CLEAR_EN.

Ports:
- clk  in  1  single clock; all logic on the rising edge.
- rst  in  1  reset, synchronous and active-high.
- cmd_valid  in  1  command present.
- cmd_code  in  3  000 NOP, 001 dark L, 010 dark R, 011 dark both, 100 clear L, 101 clear R, 110 clear both, 111 toggle both.
- cmd_ready  out  1  sequencer can accept; high only in IDLE.
- l_start  out  1  left darken pulse to drive stage.
- r_start  out  1  right darken pulse.
- l_clear  out  1  left clear pulse.
- r_clear  out  1  right clear pulse.
- busy  out  1  high in PULSE or SETTLE.
- l_dark  out  1  commanded left state, 1 = dark.
- r_dark  out  1  commanded right state.
- cmd_err  out  1  one-cycle flag on an accepted NOP.

Behaviour:
- Reset while rst=1 at a clock edge; may occur mid-operation:
  - state -> IDLE; all pulse outputs, busy, l_dark, r_dark, cmd_err and counters -> 0.
  - cmd_ready = 0 while rst is high and 1 from the first cycle after rst falls.
  - Any in-progress pulse ends immediately.
- All outputs are registered.
- Accept occurs on a rising edge with cmd_valid=1 and cmd_ready=1. cmd_code is sampled only at accept.
- Per-lens target:
  - dark codes target 1; clear codes target 0; toggle targets the inverse of the current state.
  - A lens needs action only if its target differs from its current l_dark/r_dark value.
  - A lens needing darkening asserts its start pulse; a lens needing clearing asserts its clear pulse.
- States:
  - IDLE: cmd_ready=1.
    - Accept with at least one lens needing action -> PULSE.
    - Accept with no action needed (redundant command or NOP) -> stay in IDLE. No pulse; cmd_ready remains 1.
  - PULSE: selected outputs high for exactly PULSE_LEN cycles, starting the cycle after accept. l_dark/r_dark update on the first PULSE cycle. After PULSE_LEN cycles -> SETTLE.
  - SETTLE: all pulse outputs 0. Counts SETTLE_CYCLES cycles, then -> IDLE.
- Timing: cmd_ready is low for PULSE_LEN+SETTLE_CYCLES cycles after an acting accept.
- Both lenses switch in the same cycles. start and clear for the same lens are never high together.
- cmd_err: high for 1 cycle following an accepted NOP.
- cmd_valid held high while not ready: no effect. Command is taken at the first IDLE edge.
- Counters saturate at their terminal count; no wrap.

Optional Feature:
- Macro LENS_AUTO_CLEAR_EN.
- When defined:
  - In IDLE with l_dark|r_dark=1, an idle counter increments every cycle.
  - On reaching AUTO_CLEAR_CYCLES, an internal clear-both is issued, with the same behaviour as code 110. Only the dark lens(es) pulse.
  - The counter clears on any accept, on leaving IDLE, and when both lenses are clear.
  - If an external accept and auto-trigger coincide in the same cycle, the external command wins and the counter clears.
  - An auto-clear does not raise cmd_err.
- When undefined: no idle counter is built; AUTO_CLEAR_CYCLES is ignored.

Test Plan:
- Use PULSE_LEN=2, SETTLE_CYCLES=10, AUTO_CLEAR_CYCLES=20.
1. Reset then code 011 accepted at cycle N -> l_start=r_start=1 in cycles N+1..N+2; l_dark=r_dark=1 from N+1; cmd_ready=1 again at N+13.
2. Lenses dark, code 001 -> no pulse, cmd_ready stays 1, state unchanged; then code 100 -> l_clear only, 2 cycles, l_dark=0, r_dark=1.
3. L dark / R clear, code 111 -> l_clear and r_start both high for 2 cycles; flags become 0/1.
4. cmd_valid held high during SETTLE with code 110 -> ignored until IDLE, accepted on the first ready edge. NOP accept -> cmd_err high exactly 1 cycle.
5. rst asserted on the second PULSE cycle -> all outputs 0 next edge; cmd_ready=1 the cycle after rst falls; flags 0.
6. With LENS_AUTO_CLEAR_EN: darken R, then idle -> r_clear pulses 20 cycles after IDLE is re-entered; an external command on the trigger cycle pre-empts it.
